b1_calc: RTL and testbench

- Serial BIP-8 (B1) calculator for the STM-1 transmit path.
- Sits directly downstream of the transmit scrambler and consumes its serial output bit stream and its start-of-frame pulse.
- Accumulates even parity per bit position over every bit of a complete scrambled frame. At each frame boundary it presents the result as the B1 byte to be inserted into the next frame.
- Also checks frame length between consecutive boundaries.

---
 rtl/b1_calc.sv | 81 ++++++++
 tb/tb_b1_calc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/b1_calc.sv
// Serial BIP-8 (B1) calculator for the STM-1 transmit path.
// Accumulates per-bit-position even parity over each scrambled frame and checks frame length.
module b1_calc #(
    parameter int FRAME_BITS = 19440,
    parameter int CNT_W      = 15
) (
    input  logic       clk155,
    input  logic       rst,
    input  logic       sdi,
    input  logic       sof,
    output logic [7:0] b1,
    output logic       b1_vld,
    output logic       b1_rdy,
    output logic       len_err,
    output logic [2:0] bitpos
);

    localparam logic [CNT_W-1:0] FC_MAX    = '1;
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] FC_ONE    = CNT_W'(1);

    logic [2:0]       p_reg;
    logic [2:0]       acc_idx;
    logic [7:0]       acc;
    logic [7:0]       acc_nxt;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] fc_nxt;
    logic             locked;

    assign bitpos  = p_reg;
    assign acc_idx = 3'd7 - p_reg;

    // The sof bit already belongs to the new frame, so it seeds bit 7 of the fresh accumulator.
    always_comb begin
        acc_nxt = acc;
        if (sof) begin
            acc_nxt = {sdi, 7'b0};
        end else begin
            acc_nxt[acc_idx] = acc[acc_idx] ^ sdi;
        end
    end

    always_comb begin
        fc_nxt = fc;
        if (sof) begin
            fc_nxt = FC_ONE;
        end else if (fc != FC_MAX) begin
            fc_nxt = fc + FC_ONE;
        end
    end

    always_ff @(posedge clk155 or negedge rst) begin
        if (!rst) begin
            p_reg   <= 3'd0;
            acc     <= 8'h00;
            fc      <= '0;
            locked  <= 1'b0;
            b1      <= 8'h00;
            b1_vld  <= 1'b0;
            b1_rdy  <= 1'b0;
            len_err <= 1'b0;
        end else begin
            p_reg   <= sof ? 3'd1 : p_reg + 3'd1;
            acc     <= acc_nxt;
            fc      <= fc_nxt;
            b1_vld  <= 1'b0;
            len_err <= 1'b0;
            if (sof) begin
                locked <= 1'b1;
                // The first boundary after reset only locks; the partial frame before it is discarded.
                if (locked) begin
                    b1      <= acc;
                    b1_vld  <= 1'b1;
                    b1_rdy  <= 1'b1;
                    len_err <= (fc != FRAME_LEN);
                end
            end
        end
    end

endmodule

// File: tb/tb_b1_calc.sv
// Self-checking bench for b1_calc: a bit-level parity model feeds a scoreboard of expected
// B1 results, which are compared in the exact cycle the DUT should publish them.
module tb_b1_calc;

    localparam int FRAME_BITS = 19440;
    localparam logic [7:0] BYTE0   = 8'hA5;
    localparam logic [7:0] BYTE100 = 8'h0F;

    logic       clk155 = 1'b0;
    logic       rst    = 1'b0;
    logic       sdi    = 1'b0;
    logic       sof    = 1'b0;
    logic [7:0] b1;
    logic       b1_vld;
    logic       b1_rdy;
    logic       len_err;
    logic [2:0] bitpos;

    b1_calc #(.FRAME_BITS(FRAME_BITS), .CNT_W(15)) dut (
        .clk155  (clk155),
        .rst     (rst),
        .sdi     (sdi),
        .sof     (sof),
        .b1      (b1),
        .b1_vld  (b1_vld),
        .b1_rdy  (b1_rdy),
        .len_err (len_err),
        .bitpos  (bitpos)
    );

    always #5 clk155 = ~clk155;

    typedef struct {
        logic [7:0] b1;
        logic       len_err;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] m_acc = 8'h00;
    int         m_pos = 0;
    bit         m_locked = 1'b0;

    always @(posedge clk155) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic dbit(input int kind, input int i);
        case (kind)
            1: return 1'b1;
            2: return (i == 0 || i == 9);
            3: begin
                if (i < 8) return BYTE0[7-i];
                if (i >= 800 && i < 808) return BYTE100[807-i];
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    // Drives one bit (called at a negedge) and advances the reference model.
    task automatic drive(input logic s, input logic d);
        exp_t e;
        sof = s;
        sdi = d;
        if (s) begin
            if (m_locked) begin
                e.b1 = m_acc;
                e.len_err = (m_pos != FRAME_BITS);
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
            m_locked = 1'b1;
            m_acc = 8'h00;
            m_pos = 0;
        end
        m_acc[3'(7 - (m_pos % 8))] = m_acc[3'(7 - (m_pos % 8))] ^ d;
        m_pos++;
    endtask

    // One frame of n bits starting with sof; lit >= 0 is the B1 expected from the frame it closes.
    task automatic frame(input int n, input int kind, input int lit);
        for (int i = 0; i < n; i++) begin
            @(negedge clk155);
            if (i == 1 && lit >= 0) chk("b1_lit", b1, lit);
            if (i == 3) chk("bitpos", bitpos, 3);
            drive(i == 0, dbit(kind, i));
        end
    endtask

    always @(negedge clk155) begin
        if (rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("b1_vld", b1_vld, 1);
                chk("b1", b1, e.b1);
                chk("len_err", len_err, e.len_err);
                chk("b1_rdy", b1_rdy, 1);
            end else begin
                if (b1_vld) chk("b1_vld_spurious", b1_vld, 0);
                if (len_err) chk("len_err_spurious", len_err, 0);
            end
        end
    end

    initial begin
        #12;
        chk("rst_b1", b1, 0);
        chk("rst_vld", b1_vld, 0);
        chk("rst_rdy", b1_rdy, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_bitpos", bitpos, 0);
        @(negedge clk155);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk155);
            drive(1'b0, 1'b1);
        end
        frame(FRAME_BITS, 0, -1);
        chk("rdy_after_lock", b1_rdy, 0);
        frame(FRAME_BITS, 1, 8'h00);
        frame(1000, 2, 8'h00);
        frame(1000, 0, 8'hC0);
        frame(1000, 3, 8'h00);
        frame(FRAME_BITS + 1, 0, 8'hAA);
        frame(1, 0, -1);
        frame(1, 1, -1);
        frame(10, 0, 8'h80);
        frame(30, 0, 8'h00);

        chk("rdy_before_rst", b1_rdy, 1);
        @(posedge clk155);
        #2 rst = 1'b0;
        #1;
        chk("midrst_b1", b1, 0);
        chk("midrst_vld", b1_vld, 0);
        chk("midrst_rdy", b1_rdy, 0);
        chk("midrst_len_err", len_err, 0);
        chk("midrst_bitpos", bitpos, 0);
        exp_q.delete();
        m_locked = 1'b0;
        sof = 1'b0;
        @(negedge clk155);
        @(negedge clk155);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk155);
            drive(1'b0, 1'b1);
        end
        frame(50, 2, 8'h00);
        frame(3, 0, 8'hC0);
        @(negedge clk155);
        drive(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk155);
            drive(1'b0, 1'b0);
        end
        @(negedge clk155);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
